spdif_tx: RTL and testbench



---
 rtl/spdif_pkg.sv | 43 ++++
 rtl/spdif_bmc.sv | 50 +++++
 rtl/spdif_tx.sv | 128 ++++++++++++
 tb/tb_spdif_tx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spdif_pkg.sv
// Shared constants for the S/PDIF consumer transmitter: preambles, slot map,
// channel-status layout and frame/block sizes.
package spdif_pkg;

  localparam int CELLS_PER_FRAME  = 128;
  localparam int FRAMES_PER_BLOCK = 192;

  // Preamble cell patterns assuming the line sat at 0 before the preamble
  localparam logic [7:0] PRE_B = 8'b11101000;
  localparam logic [7:0] PRE_M = 8'b11100010;
  localparam logic [7:0] PRE_W = 8'b11100100;

  typedef enum logic [1:0] {
    PRE_SEL_B,
    PRE_SEL_M,
    PRE_SEL_W
  } pre_sel_t;

  localparam int SLOT_AUX       = 4;
  localparam int SLOT_AUDIO_LSB = 12;
  localparam int SLOT_AUDIO_MSB = 27;
  localparam int SLOT_V         = 28;
  localparam int SLOT_U         = 29;
  localparam int SLOT_C         = 30;
  localparam int SLOT_P         = 31;

  localparam int CS_PRO    = 0;
  localparam int CS_DATA   = 1;
  localparam int CS_COPY   = 2;
  localparam int CS_FS_LSB = 24;

  function automatic logic cs_bit(input logic [7:0] frame, input logic copy_ok,
                                  input logic [3:0] fs);
    logic b;
    b = 1'b0;
    if (frame == 8'(CS_COPY))
      b = copy_ok;
    else if (frame >= 8'(CS_FS_LSB) && frame < 8'(CS_FS_LSB + 4))
      b = fs[2'(frame - 8'(CS_FS_LSB))];
    return b;
  endfunction

endpackage

// File: rtl/spdif_bmc.sv
// Biphase-mark line coder: owns the line level and drives the registered
// S/PDIF output one cell per tick.
module spdif_bmc
  import spdif_pkg::*;
(
  input  logic       mclk,
  input  logic       rst,
  input  logic       tick,
  input  logic [5:0] sub_cell,
  input  pre_sel_t   pre_sel,
  input  logic       slot_bit,
  output logic       spdif
);

  logic       line_reg;
  logic       inv_reg;
  logic       line_next;
  logic [7:0] pattern;

  always_comb begin
    pattern   = PRE_B;
    line_next = line_reg;
    case (pre_sel)
      PRE_SEL_M: pattern = PRE_M;
      PRE_SEL_W: pattern = PRE_W;
      default:   pattern = PRE_B;
    endcase
    // Preamble cells are inverted when the line entered the preamble high
    if (sub_cell[5:3] == 3'd0)
      line_next = pattern[~sub_cell[2:0]] ^ ((sub_cell[2:0] == 3'd0) ? line_reg : inv_reg);
    else if (!sub_cell[0])
      line_next = ~line_reg;
    else if (slot_bit)
      line_next = ~line_reg;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      line_reg <= 1'b0;
      inv_reg  <= 1'b0;
    end else if (tick) begin
      line_reg <= line_next;
      if (sub_cell == 6'd0)
        inv_reg <= line_reg;
    end
  end

  assign spdif = line_reg;

endmodule

// File: rtl/spdif_tx.sv
// S/PDIF consumer transmitter: cell/frame counters, sample buffering, channel
// status and parity. Optional macro SPDIF_VALIDITY_EN marks underrun frames V=1.
module spdif_tx
  import spdif_pkg::*;
#(
  parameter int         CLK_DIV = 4,
  parameter logic       COPY_OK = 1'b1,
  parameter logic [3:0] CS_FS   = 4'b0011
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic        dtr,
  output logic        drq,
  output logic        spdif,
  output logic        underrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_reg;
  logic [6:0]       cell_reg;
  logic [7:0]       frame_reg;
  logic [31:0]      hold_reg;
  logic [31:0]      frame_buf_reg;
  logic             pending_reg;
  logic             drq_reg;
  logic             underrun_reg;
`ifdef SPDIF_VALIDITY_EN
  logic             starve_reg;
`endif

  logic        tick;
  logic        div_wrap;
  logic        latch;
  logic [4:0]  slot;
  logic [15:0] sample;
  logic        v_bit;
  logic        c_bit;
  logic        parity;
  logic        slot_bit;
  pre_sel_t    pre_sel;

  assign tick     = (div_reg == '0);
  assign div_wrap = (div_reg == DIV_W'(CLK_DIV - 1));
  assign latch    = tick && (cell_reg == 7'd0);

  always_ff @(posedge mclk) begin
    if (rst) begin
      div_reg       <= '0;
      cell_reg      <= 7'd0;
      frame_reg     <= 8'd0;
      hold_reg      <= 32'd0;
      frame_buf_reg <= 32'd0;
      pending_reg   <= 1'b0;
      drq_reg       <= 1'b0;
      underrun_reg  <= 1'b0;
`ifdef SPDIF_VALIDITY_EN
      starve_reg    <= 1'b0;
`endif
    end else begin
      div_reg <= div_wrap ? '0 : div_reg + DIV_W'(1);
      if (div_wrap) begin
        cell_reg <= cell_reg + 7'd1;
        if (cell_reg == 7'(CELLS_PER_FRAME - 1))
          frame_reg <= (frame_reg == 8'(FRAMES_PER_BLOCK - 1)) ? 8'd0 : frame_reg + 8'd1;
      end
      drq_reg <= latch;
      if (dtr)
        hold_reg <= data;
      // A strobe on the latch cycle is consumed straight into the frame
      if (latch) begin
        frame_buf_reg <= dtr ? data : hold_reg;
        pending_reg   <= 1'b0;
        if (!pending_reg && !dtr)
          underrun_reg <= 1'b1;
`ifdef SPDIF_VALIDITY_EN
        starve_reg <= !pending_reg && !dtr;
`endif
      end else if (dtr) begin
        pending_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    slot     = cell_reg[5:1];
    sample   = cell_reg[6] ? frame_buf_reg[15:0] : frame_buf_reg[31:16];
    v_bit    = 1'b0;
`ifdef SPDIF_VALIDITY_EN
    if (starve_reg) begin
      sample = 16'd0;
      v_bit  = 1'b1;
    end
`endif
    c_bit    = cs_bit(frame_reg, COPY_OK, CS_FS);
    parity   = ^sample ^ v_bit ^ c_bit;
    slot_bit = 1'b0;
    if (slot >= 5'(SLOT_AUDIO_LSB) && slot <= 5'(SLOT_AUDIO_MSB))
      slot_bit = sample[4'(slot - 5'(SLOT_AUDIO_LSB))];
    else if (slot == 5'(SLOT_V))
      slot_bit = v_bit;
    else if (slot == 5'(SLOT_C))
      slot_bit = c_bit;
    else if (slot == 5'(SLOT_P))
      slot_bit = parity;
    if (cell_reg[6])
      pre_sel = PRE_SEL_W;
    else if (frame_reg == 8'd0)
      pre_sel = PRE_SEL_B;
    else
      pre_sel = PRE_SEL_M;
  end

  spdif_bmc u_bmc (
    .mclk     (mclk),
    .rst      (rst),
    .tick     (tick),
    .sub_cell (cell_reg[5:0]),
    .pre_sel  (pre_sel),
    .slot_bit (slot_bit),
    .spdif    (spdif)
  );

  assign drq      = drq_reg;
  assign underrun = underrun_reg;

endmodule

// File: tb/tb_spdif_tx.sv
// Directed plus randomized bench for spdif_tx against a frame-level model
// built from the biphase-mark and subframe rules.
module tb_spdif_tx;

  localparam int DIV       = 2;
  localparam int FRAME_CYC = 128 * DIV;
  localparam logic [7:0] PB = 8'b11101000;
  localparam logic [7:0] PM = 8'b11100010;
  localparam logic [7:0] PW = 8'b11100100;

  logic        mclk = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] data = 32'd0;
  logic        dtr  = 1'b0;
  logic        drq;
  logic        spdif;
  logic        underrun;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hold, m_fbuf;
  logic        m_pending, m_starve, m_underrun, m_level;
  int          m_frame;

  spdif_tx #(.CLK_DIV(DIV)) dut (
    .mclk     (mclk),
    .rst      (rst),
    .data     (data),
    .dtr      (dtr),
    .drq      (drq),
    .spdif    (spdif),
    .underrun (underrun)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_cs(input int f);
    return (f == 2) || (f == 24) || (f == 25);
  endfunction

  // One subframe as 64 line cells (bit i = cell i), plus the level it ends on
  function automatic void build_sub(input logic [15:0] s, input logic v, input logic c,
                                    input logic [7:0] pre, input logic lvl_in,
                                    output logic [63:0] cells, output logic lvl_out);
    logic [31:0] slots;
    logic        lvl;
    int          ones;
    slots = 32'd0;
    for (int i = 0; i < 16; i++) slots[12 + i] = s[i];
    slots[28] = v;
    slots[30] = c;
    ones = 0;
    for (int i = 4; i <= 30; i++) ones += int'(slots[i]);
    slots[31] = (ones % 2 == 1);
    cells = 64'd0;
    for (int i = 0; i < 8; i++) cells[i] = pre[7 - i] ^ lvl_in;
    lvl = cells[7];
    for (int sl = 4; sl < 32; sl++) begin
      lvl = ~lvl;
      cells[2 * sl] = lvl;
      if (slots[sl]) lvl = ~lvl;
      cells[2 * sl + 1] = lvl;
    end
    lvl_out = lvl;
  endfunction

  task automatic model_latch(input logic at, input logic [31:0] v);
    if (at) begin
      m_fbuf   = v;
      m_hold   = v;
      m_starve = 1'b0;
    end else begin
      m_fbuf   = m_hold;
      m_starve = !m_pending;
      if (m_starve) m_underrun = 1'b1;
    end
    m_pending = 1'b0;
  endtask

  task automatic do_reset(input logic with_dtr, input logic [31:0] v);
    rst = 1'b1;
    dtr = 1'b0;
    repeat (3) begin
      @(posedge mclk); #1;
      check("rst_spdif", 64'(spdif), 64'd0);
    end
    check("rst_drq", 64'(drq), 64'd0);
    check("rst_underrun", 64'(underrun), 64'd0);
    rst = 1'b0;
    if (with_dtr) begin
      dtr  = 1'b1;
      data = v;
    end
    m_hold = 32'd0; m_fbuf = 32'd0; m_pending = 1'b0; m_starve = 1'b0;
    m_underrun = 1'b0; m_level = 1'b0; m_frame = 0;
    model_latch(with_dtr, v);
    @(posedge mclk); #1;
  endtask

  // Entered one cycle after a latch edge; leaves one cycle after the next one
  task automatic run_frame(input int mode, input logic [31:0] mid_v,
                           input logic [31:0] lat_v, input int abort_cell);
    logic [127:0] cap;
    logic [63:0]  el, er;
    logic         lv1, lv2, wbad, vb, cb;
    logic [15:0]  sl, sr, dl, dr;
    int           ones;
    dtr = 1'b0;
    check($sformatf("drq_start_f%0d", m_frame), 64'(drq), 64'd1);
    check($sformatf("underrun_f%0d", m_frame), 64'(underrun), 64'(m_underrun));
    sl = m_fbuf[31:16];
    sr = m_fbuf[15:0];
    vb = 1'b0;
`ifdef SPDIF_VALIDITY_EN
    if (m_starve) begin
      sl = 16'd0; sr = 16'd0; vb = 1'b1;
    end
`endif
    cb = exp_cs(m_frame);
    build_sub(sl, vb, cb, (m_frame == 0) ? PB : PM, m_level, el, lv1);
    build_sub(sr, vb, cb, PW, lv1, er, lv2);
    cap  = '0;
    wbad = 1'b0;
    for (int k = 0; k < FRAME_CYC; k++) begin
      if (k % DIV == 0) cap[k / DIV] = spdif;
      else if (spdif !== cap[k / DIV]) wbad = 1'b1;
      if (k == 1) check("drq_low", 64'(drq), 64'd0);
      if (abort_cell >= 0 && k == abort_cell * DIV) begin
        rst = 1'b1;
        @(posedge mclk); #1;
        check("abort_spdif", 64'(spdif), 64'd0);
        check("abort_drq", 64'(drq), 64'd0);
        check("abort_underrun", 64'(underrun), 64'd0);
        return;
      end
      if (mode[0] && k == 100) begin
        dtr = 1'b1; data = mid_v;
        m_hold = mid_v; m_pending = 1'b1;
      end
      if (mode[0] && k == 101) dtr = 1'b0;
      if (mode[1] && k == FRAME_CYC - 1) begin
        dtr = 1'b1; data = lat_v;
      end
      @(posedge mclk); #1;
    end
    check($sformatf("left_f%0d", m_frame), cap[63:0], el);
    check($sformatf("right_f%0d", m_frame), cap[127:64], er);
    check($sformatf("cellwidth_f%0d", m_frame), 64'(wbad), 64'd0);
    for (int i = 0; i < 16; i++) begin
      dl[i] = cap[2 * (12 + i)] ^ cap[2 * (12 + i) + 1];
      dr[i] = cap[64 + 2 * (12 + i)] ^ cap[64 + 2 * (12 + i) + 1];
    end
    check($sformatf("dec_left_f%0d", m_frame), 64'(dl), 64'(sl));
    check($sformatf("dec_right_f%0d", m_frame), 64'(dr), 64'(sr));
    check($sformatf("dec_v_f%0d", m_frame), 64'(cap[56] ^ cap[57]), 64'(vb));
    check($sformatf("dec_c_f%0d", m_frame), 64'(cap[60] ^ cap[61]), 64'(cb));
    ones = 0;
    for (int s = 4; s < 32; s++) ones += int'(cap[2 * s] ^ cap[2 * s + 1]);
    check($sformatf("parity_f%0d", m_frame), 64'(ones % 2), 64'd0);
    m_frame = (m_frame + 1) % 192;
    m_level = lv2;
    model_latch(mode[1], lat_v);
  endtask

  initial begin
    int mode;
    logic [31:0] a, b;

    // Phase 1: idle start, directed sample, then a full block plus one frame
    do_reset(1'b0, 32'd0);
    run_frame(1, 32'h8001_7FFE, 32'd0, -1);
    for (int f = 1; f <= 192; f++) begin
      mode = int'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      run_frame(mode, a, b, -1);
    end

    // Phase 2: strobe on the latch cycle overrides a pending value, then abort
    do_reset(1'b1, 32'h0BAD_F00D);
    run_frame(3, 32'hAAAA_5555, 32'h1234_5678, -1);
    for (int f = 1; f < 10; f++) begin
      mode = int'($urandom_range(1, 3));
      a = $urandom;
      b = $urandom;
      run_frame(mode, a, b, -1);
    end
    run_frame(0, 32'd0, 32'd0, 70);

    // Phase 3: restart after abort, then starve for several frames
    do_reset(1'b1, 32'h5A5A_C3C3);
    for (int f = 0; f < 4; f++) run_frame(0, 32'd0, 32'd0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
